// File: rtl/sipo_packer_if.sv
// Stream bundle for sipo_packer: serial beat input side and packed word output side.
interface sipo_packer_if #(
  parameter int SERIAL_WIDTH = 8,
  parameter int DEPTH        = 5
);
  localparam int PARALLEL_WIDTH = SERIAL_WIDTH * DEPTH;
  localparam int CNT_WIDTH      = $clog2(DEPTH + 1);

  logic [SERIAL_WIDTH-1:0]   data_in;
  logic                      data_in_last;
  logic                      data_in_valid;
  logic                      data_in_ready;
  logic [PARALLEL_WIDTH-1:0] data_out;
  logic [CNT_WIDTH-1:0]      data_out_count;
  logic                      data_out_last;
  logic                      data_out_valid;
  logic                      data_out_ready;

  modport master (
    output data_in, data_in_last, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_count, data_out_last, data_out_valid
  );

  modport slave (
    input  data_in, data_in_last, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_count, data_out_last, data_out_valid
  );
endinterface

// File: rtl/sipo_packer.sv
// Serial-in parallel-out packer: gathers DEPTH beats (or fewer, closed by data_in_last)
// into one word, with a one-word accumulator backing a registered output stage.
module sipo_packer #(
  parameter int SERIAL_WIDTH = 8,
  parameter int DEPTH        = 5,
  parameter int LEFT_SHIFT   = 1
) (
  input  logic           clk_i,
  input  logic           arst_n,
  sipo_packer_if.slave   bus
);
  localparam int PARALLEL_WIDTH = SERIAL_WIDTH * DEPTH;
  localparam int CNT_WIDTH      = $clog2(DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DEPTH - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t                    state, state_next;
  logic [PARALLEL_WIDTH-1:0] acc, acc_next, shifted;
  logic [CNT_WIDTH-1:0]      acc_cnt, acc_cnt_next, cnt_inc;
  logic                      acc_last, acc_last_next;
  logic [PARALLEL_WIDTH-1:0] out_data, out_data_next;
  logic [CNT_WIDTH-1:0]      out_cnt, out_cnt_next;
  logic                      out_last, out_last_next;
  logic                      out_valid, out_valid_next;
  logic                      beat_take, out_take, completes;

  if (LEFT_SHIFT != 0) begin : g_left
    assign shifted = {acc[PARALLEL_WIDTH-SERIAL_WIDTH-1:0], bus.data_in};
  end else begin : g_right
    assign shifted = {bus.data_in, acc[PARALLEL_WIDTH-1:SERIAL_WIDTH]};
  end

  assign cnt_inc   = acc_cnt + CNT_WIDTH'(1);
  assign beat_take = bus.data_in_valid && (state == FILL);
  assign out_take  = out_valid && bus.data_out_ready;
  assign completes = (acc_cnt == LAST_CNT) || bus.data_in_last;

  always_comb begin
    state_next     = state;
    acc_next       = acc;
    acc_cnt_next   = acc_cnt;
    acc_last_next  = acc_last;
    out_data_next  = out_data;
    out_cnt_next   = out_cnt;
    out_last_next  = out_last;
    out_valid_next = out_valid;
    case (state)
      FILL: begin
        if (out_take) out_valid_next = 1'b0;
        if (beat_take) begin
          if (completes && (!out_valid || bus.data_out_ready)) begin
            out_data_next  = shifted;
            out_cnt_next   = cnt_inc;
            out_last_next  = bus.data_in_last;
            out_valid_next = 1'b1;
            acc_next       = '0;
            acc_cnt_next   = '0;
            acc_last_next  = 1'b0;
          end else begin
            // A completed word parks in the accumulator (count may reach DEPTH) until the output frees.
            acc_next      = shifted;
            acc_cnt_next  = cnt_inc;
            acc_last_next = bus.data_in_last;
            if (completes) state_next = FULL;
          end
        end
      end
      FULL: begin
        if (out_take) begin
          out_data_next  = acc;
          out_cnt_next   = acc_cnt;
          out_last_next  = acc_last;
          out_valid_next = 1'b1;
          acc_next       = '0;
          acc_cnt_next   = '0;
          acc_last_next  = 1'b0;
          state_next     = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      state     <= FILL;
      acc       <= '0;
      acc_cnt   <= '0;
      acc_last  <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      acc_cnt   <= acc_cnt_next;
      acc_last  <= acc_last_next;
      out_data  <= out_data_next;
      out_cnt   <= out_cnt_next;
      out_last  <= out_last_next;
      out_valid <= out_valid_next;
    end
  end

  assign bus.data_in_ready  = (state == FILL);
  assign bus.data_out       = out_data;
  assign bus.data_out_count = out_cnt;
  assign bus.data_out_last  = out_last;
  assign bus.data_out_valid = out_valid;
endmodule

// File: tb/tb_sipo_packer.sv
// Directed bench for sipo_packer: LEFT_SHIFT=1 and LEFT_SHIFT=0 instances run in lockstep.
module tb_sipo_packer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_last = 1'b0;
  logic       din_valid = 1'b0;
  logic       dout_ready = 1'b1;

  always #5 clk = ~clk;

  sipo_packer_if #(.SERIAL_WIDTH(8), .DEPTH(4)) bus_l ();
  sipo_packer_if #(.SERIAL_WIDTH(8), .DEPTH(4)) bus_r ();

  assign bus_l.data_in        = din;
  assign bus_l.data_in_last   = din_last;
  assign bus_l.data_in_valid  = din_valid;
  assign bus_l.data_out_ready = dout_ready;
  assign bus_r.data_in        = din;
  assign bus_r.data_in_last   = din_last;
  assign bus_r.data_in_valid  = din_valid;
  assign bus_r.data_out_ready = dout_ready;

  sipo_packer #(.SERIAL_WIDTH(8), .DEPTH(4), .LEFT_SHIFT(1)) dut_l (
    .clk_i(clk), .arst_n(rst_n), .bus(bus_l)
  );
  sipo_packer #(.SERIAL_WIDTH(8), .DEPTH(4), .LEFT_SHIFT(0)) dut_r (
    .clk_i(clk), .arst_n(rst_n), .bus(bus_r)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        last;
  } word_t;

  word_t q_l[$];
  word_t q_r[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whenever a word is offered it must match the oldest outstanding word, held or not.
  always @(negedge clk) begin
    if (rst_n && bus_l.data_out_valid) begin
      if (q_l.size() == 0) check("spurious_l", bus_l.data_out_valid, 1'b0);
      else begin
        check("word_l", {bus_l.data_out, bus_l.data_out_count, bus_l.data_out_last}, q_l[0]);
        if (dout_ready) void'(q_l.pop_front());
      end
    end
    if (rst_n && bus_r.data_out_valid) begin
      if (q_r.size() == 0) check("spurious_r", bus_r.data_out_valid, 1'b0);
      else begin
        check("word_r", {bus_r.data_out, bus_r.data_out_count, bus_r.data_out_last}, q_r[0]);
        if (dout_ready) void'(q_r.pop_front());
      end
    end
  end

  task automatic push(input logic [31:0] wl, input logic [31:0] wr,
                      input logic [2:0] cnt, input logic last);
    q_l.push_back('{data: wl, cnt: cnt, last: last});
    q_r.push_back('{data: wr, cnt: cnt, last: last});
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    din       = d;
    din_last  = last;
    din_valid = 1'b1;
    check("in_ready", {bus_l.data_in_ready, bus_r.data_in_ready}, 2'b11);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    din_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && (q_l.size() != 0 || q_r.size() != 0); i++) begin
      @(posedge clk);
      #2;
    end
    check({tag, "_drained"}, q_l.size() + q_r.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_l"}, {bus_l.data_out, bus_l.data_out_count, bus_l.data_out_last,
                            bus_l.data_out_valid}, '0);
    check({tag, "_out_r"}, {bus_r.data_out, bus_r.data_out_count, bus_r.data_out_last,
                            bus_r.data_out_valid}, '0);
    check({tag, "_ready"}, {bus_l.data_in_ready, bus_r.data_in_ready}, 2'b11);
  endtask

  initial begin
    #12;
    check_reset_outputs("por");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("ready_after_release", {bus_l.data_in_ready, bus_r.data_in_ready}, 2'b11);

    // Full word, both lane orders; valid exactly one cycle after the closing beat.
    push(32'h11223344, 32'h44332211, 3'd4, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("valid_early", {bus_l.data_out_valid, bus_r.data_out_valid}, 2'b00);
    send(8'h44, 1'b0);
    check("valid_next", {bus_l.data_out_valid, bus_r.data_out_valid}, 2'b11);
    idle(2);
    drain("full");

    // Early close, single-beat word, and last on the DEPTH-th beat.
    push(32'h0000AABB, 32'hBBAA0000, 3'd2, 1'b1);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    push(32'h000000CC, 32'hCC000000, 3'd1, 1'b1);
    send(8'hCC, 1'b1);
    push(32'h01020304, 32'h04030201, 3'd4, 1'b1);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    idle(2);
    drain("partial");

    // Backpressure: second word parks in the accumulator, beats offered in FULL are dropped.
    dout_ready = 1'b0;
    push(32'h01020304, 32'h04030201, 3'd4, 1'b0);
    push(32'h05060708, 32'h08070605, 3'd4, 1'b0);
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    check("full_not_ready", {bus_l.data_in_ready, bus_r.data_in_ready}, 2'b00);
    din       = 8'h99;
    din_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    check("full_hold_ready", {bus_l.data_in_ready, bus_r.data_in_ready}, 2'b00);
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk);
    #2;
    check("full_release_ready", {bus_l.data_in_ready, bus_r.data_in_ready}, 2'b11);
    idle(2);
    drain("backpressure");

    // Sustained one beat per cycle: 16 beats, four words, ready never drops.
    for (int w = 0; w < 4; w++) begin
      logic [7:0] b0;
      b0 = 8'(8'h20 + 4 * w);
      push({b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0},
           3'd4, 1'b0);
    end
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0);
    idle(2);
    drain("stream");

    // Reset with a held word and a partial word in flight.
    dout_ready = 1'b0;
    push(32'h0A0B0C0D, 32'h0D0C0B0A, 3'd4, 1'b0);
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b0);
    send(8'h0C, 1'b0);
    send(8'h0D, 1'b0);
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q_l.delete();
    q_r.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n      = 1'b1;
    dout_ready = 1'b1;
    check_reset_outputs("postreset");
    push(32'h11223344, 32'h44332211, 3'd4, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    idle(3);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_packer.md
SIPO_PACKER -- requirements
Module: sipo_packer

Interface
REQ-001 Parameter SERIAL_WIDTH, default 8: bits per input beat, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 5: beats per full output word, SHALL be >= 2.
REQ-003 Parameter LEFT_SHIFT, default 1: lane order, 1 = new beats enter lane 0 and older beats shift up; 0 = new beats enter lane DEPTH-1 and older beats shift down.
REQ-004 Localparams SHALL be PARALLEL_WIDTH = SERIAL_WIDTH*DEPTH and CNT_WIDTH = $clog2(DEPTH+1); lane i = bits [i*SERIAL_WIDTH +: SERIAL_WIDTH].
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk_i  in  1  rising-edge clock
- arst_n  in  1  asynchronous active-low reset
- data_in  in  SERIAL_WIDTH  serial beat
- data_in_last  in  1  beat closes current word early
- data_in_valid  in  1  beat offered
- data_in_ready  out  1  beat can be accepted
- data_out  out  PARALLEL_WIDTH  packed word
- data_out_count  out  CNT_WIDTH  beats in word, 1..DEPTH
- data_out_last  out  1  word was closed by data_in_last
- data_out_valid  out  1  word offered
- data_out_ready  in  1  sink accepts word

Function
REQ-006 A beat SHALL be accepted on a rising edge where data_in_valid & data_in_ready; a word SHALL be transferred on an edge where data_out_valid & data_out_ready.
REQ-007 The block SHALL contain an accumulator (lanes, beat count 0..DEPTH-1) and an output register (data_out, count, last, valid); state machine FILL / FULL.
REQ-008 data_in_ready SHALL be 1 in FILL and 0 in FULL, registered-state only, with no combinational path from any input.
REQ-009 An accepted beat SHALL complete the word when beat count+1 == DEPTH or data_in_last = 1; otherwise it SHALL be shifted in and the count incremented.
REQ-010 On completion, if output register is empty or transferred on the same edge, the word SHALL load into the output register on that edge (data_out_valid high the following cycle, no bubble); the accumulator SHALL clear to zero with count 0 and state stays FILL.
REQ-011 On completion while output register is occupied and not transferred, the word SHALL stay in the accumulator and state SHALL go to FULL.
REQ-012 In FULL, on the edge the output register is transferred, the accumulator word SHALL move into it, the accumulator SHALL clear, and state SHALL return to FILL.
REQ-013 Partial word with n beats, LEFT_SHIFT=1: first beat in lane n-1, last beat in lane 0, lanes n..DEPTH-1 zero; LEFT_SHIFT=0: first beat in lane DEPTH-n, last in lane DEPTH-1, lanes 0..DEPTH-n-1 zero.
REQ-014 data_out_last SHALL equal data_in_last of the completing beat, including when it arrives on beat DEPTH (count DEPTH, last 1); a single last beat at count 0 SHALL form a word of count 1.
REQ-015 data_out, data_out_count and data_out_last SHALL hold stable while data_out_valid & ~data_out_ready.
REQ-016 Words SHALL emerge in acceptance order; no beat SHALL be lost or duplicated; sustained throughput SHALL be one beat per cycle when data_out_ready stays high.
REQ-017 Beats offered while data_in_ready = 0 SHALL be ignored.

Reset
REQ-018 While arst_n = 0, asynchronously: data_out = 0, data_out_count = 0, data_out_last = 0, data_out_valid = 0, accumulator lanes and count = 0, state FILL.
REQ-019 data_in_ready SHALL be 1 in the first cycle after reset release.
REQ-020 Reset mid-word or with words held SHALL discard all partial and pending words; no stale word SHALL appear after release.

Verification (SERIAL_WIDTH=8, DEPTH=4)
REQ-021 LEFT_SHIFT=1, beats 0x11,0x22,0x33,0x44, data_out_ready=1 -> one word 0x11223344, count 4, last 0, valid one cycle after beat 0x44.
REQ-022 LEFT_SHIFT=0, same beats -> 0x44332211, count 4.
REQ-023 LEFT_SHIFT=1, 0xAA then 0xBB with last -> 0x0000AABB, count 2, last 1; then single 0xCC with last -> 0x000000CC, count 1, last 1.
REQ-024 data_out_ready=0, eight beats 0x01..0x08 -> first word held stable, data_in_ready drops after 8th beat (FULL); raise ready -> 0x01020304 then 0x05060708, data_in_ready returns to 1.
REQ-025 Continuous 16 beats with data_out_ready=1 -> four words back-to-back, data_in_ready never low.
REQ-026 Assert arst_n=0 after 2 beats of a word, release, send 0x11..0x44 -> only 0x11223344 emitted, all outputs 0 during reset.
